// File: rtl/iram_access_unit_pkg.sv
// iram_access_unit_pkg
// Shared definitions for the 8051 internal-RAM access responder:
//   - RAM_access command codes (4-bit), as issued by the control unit
//   - operand-kind classification used to pick the access path
//   - data width of the RAM and the operand bytes
// Optional build macro used by the top: IRAM_CLEAR_ON_RESET_EN.
package iram_access_unit_pkg;

  localparam int DATA_W = 8;
  localparam int CODE_W = 4;

  typedef enum logic [CODE_W-1:0] {
    RAM_NONE       = 4'd0,
    RD_RAM_REG     = 4'd1,
    WR_RAM_REG     = 4'd2,
    RD_RAM_REG_IND = 4'd3,
    WR_RAM_REG_IND = 4'd4,
    RD_RAM_DIRECT  = 4'd5,
    RD_RAM_IM      = 4'd6,
    WR_RAM_DIRECT  = 4'd7
  } access_code_e;

  // How the operand address is obtained; K_BAD covers RAM_NONE and 8..15.
  typedef enum logic [2:0] {
    K_BAD,
    K_IMM,
    K_REG,
    K_DIR,
    K_IND
  } op_kind_e;

  function automatic op_kind_e op_kind(input logic [CODE_W-1:0] code);
    case (code)
      RD_RAM_IM:                      return K_IMM;
      RD_RAM_REG, WR_RAM_REG:         return K_REG;
      RD_RAM_DIRECT, WR_RAM_DIRECT:   return K_DIR;
      RD_RAM_REG_IND, WR_RAM_REG_IND: return K_IND;
      default:                        return K_BAD;
    endcase
  endfunction

  function automatic logic is_write(input logic [CODE_W-1:0] code);
    return (code == WR_RAM_REG) || (code == WR_RAM_REG_IND) ||
           (code == WR_RAM_DIRECT);
  endfunction

  function automatic logic is_ram_read(input logic [CODE_W-1:0] code);
    return (code == RD_RAM_REG) || (code == RD_RAM_REG_IND) ||
           (code == RD_RAM_DIRECT);
  endfunction

endpackage

// File: rtl/iram_access_unit_if.sv
// iram_access_unit_if
// Command/response bundle between the control unit (master) and the
// internal-RAM access unit (slave).
//   req, access_code, reg_sel, bank_sel, direct_addr, imm_data, wdata : master -> slave
//   busy, done, rdata, addr_err                                       : slave -> master
interface iram_access_unit_if;
  import iram_access_unit_pkg::*;

  logic              req;
  logic [CODE_W-1:0] access_code;
  logic [2:0]        reg_sel;
  logic [1:0]        bank_sel;
  logic [DATA_W-1:0] direct_addr;
  logic [DATA_W-1:0] imm_data;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              addr_err;

  modport master (
    output req, access_code, reg_sel, bank_sel, direct_addr, imm_data, wdata,
    input  busy, done, rdata, addr_err
  );

  modport slave (
    input  req, access_code, reg_sel, bank_sel, direct_addr, imm_data, wdata,
    output busy, done, rdata, addr_err
  );
endinterface

// File: rtl/iram_access_unit_array.sv
// iram_array
// DEPTH x 8 synchronous single-port RAM holding the 8051 internal data RAM.
// Address presented in cycle k gives q in cycle k+1; a write lands on the
// same edge and q returns the previous contents (read-before-write).
// Ports:
//   clk_i  : clock
//   addr_i : word address
//   we_i   : write enable
//   d_i    : write data
//   q_o    : registered read data
module iram_array
  import iram_access_unit_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic              clk_i,
  input  logic [AW-1:0]     addr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= d_i;
    end
    q_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/iram_access_unit.sv
// iram_access_unit
// Responder for the control unit's RAM_access commands. Accepts one command
// per req (sampled in IDLE only), resolves Rn / @Ri / direct / immediate
// operands, performs reads and accumulator writes against the internal RAM
// and returns rdata/addr_err with a one-cycle done strobe.
// Ports:
//   clock : system clock
//   reset : synchronous active-high reset (aborts any command in flight)
//   bus   : iram_access_unit_if.slave command/response bundle
// Build option:
//   IRAM_CLEAR_ON_RESET_EN : after reset, sweep 8'h00 through every RAM
//                            address (DEPTH cycles, busy high) before IDLE.
//
// state | meaning
// IDLE  | waiting for req, operands captured on accept
// PTR   | @Ri pointer byte being read from the register bank
// ACC   | effective address on the RAM, write strobed for WR codes
// RESP  | done high, rdata/addr_err presented
// CLEAR | (IRAM_CLEAR_ON_RESET_EN only) post-reset zero sweep
module iram_access_unit
  import iram_access_unit_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input logic              clock,
  input logic              reset,
  iram_access_unit_if.slave bus
);

  if ((1 << AW) != DEPTH) begin : g_bad_cfg
    $error("iram_access_unit: 2**AW must equal DEPTH");
  end

`ifdef IRAM_CLEAR_ON_RESET_EN
  typedef enum logic [2:0] {S_IDLE, S_PTR, S_ACC, S_RESP, S_CLEAR} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_PTR, S_ACC, S_RESP} state_e;
`endif

  state_e            state_q;
  logic [CODE_W-1:0] code_q;
  logic [DATA_W-1:0] eff_addr_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] wdata_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rdata_q;
  logic              addr_err_q;
`ifdef IRAM_CLEAR_ON_RESET_EN
  logic [AW-1:0]     clr_cnt_q;
`endif

  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_d;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] acc_addr;
  logic              in_range;
  logic [DATA_W-1:0] resp_data;

  // For @Ri the pointer byte read during PTR arrives on q in ACC and is used
  // directly as the effective address; other paths captured it on accept.
  assign acc_addr = (op_kind(code_q) == K_IND) ? ram_q : eff_addr_q;
  assign in_range = {1'b0, acc_addr} < 9'(DEPTH);

  always_comb begin
    ram_addr = (state_q == S_ACC) ? acc_addr[AW-1:0] : eff_addr_q[AW-1:0];
    ram_d    = wdata_q;
    ram_we   = 1'b0;
    // Gated with reset so an aborted command never writes on the reset edge.
    if ((state_q == S_ACC) && is_write(code_q) && in_range && !reset) begin
      ram_we = 1'b1;
    end
`ifdef IRAM_CLEAR_ON_RESET_EN
    if (state_q == S_CLEAR) begin
      // Down-counter walks DEPTH-1..0, so its complement walks 0..DEPTH-1.
      ram_addr = ~clr_cnt_q;
      ram_d    = '0;
      ram_we   = !reset;
    end
`endif
  end

  // RAM read data only exists on q during RESP, so the response byte is
  // formed there and then held in rdata_q until the next response.
  always_comb begin
    resp_data = rdata_q;
    if (is_ram_read(code_q)) begin
      resp_data = addr_err_q ? '0 : ram_q;
    end else if (code_q == RD_RAM_IM) begin
      resp_data = imm_q;
    end else if (is_write(code_q)) begin
      resp_data = addr_err_q ? '0 : wdata_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
`ifdef IRAM_CLEAR_ON_RESET_EN
      state_q   <= S_CLEAR;
      busy_q    <= 1'b1;
      clr_cnt_q <= AW'(DEPTH - 1);
`else
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
`endif
      done_q     <= 1'b0;
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
      code_q     <= RAM_NONE;
      eff_addr_q <= '0;
      imm_q      <= '0;
      wdata_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            code_q  <= bus.access_code;
            imm_q   <= bus.imm_data;
            wdata_q <= bus.wdata;
            busy_q  <= 1'b1;
            case (op_kind(bus.access_code))
              K_IMM: begin
                state_q    <= S_RESP;
                done_q     <= 1'b1;
                addr_err_q <= 1'b0;
              end
              K_REG: begin
                eff_addr_q <= 8'({bus.bank_sel, bus.reg_sel});
                state_q    <= S_ACC;
              end
              K_DIR: begin
                eff_addr_q <= bus.direct_addr;
                state_q    <= S_ACC;
              end
              K_IND: begin
                eff_addr_q <= 8'({bus.bank_sel, 2'b00, bus.reg_sel[0]});
                state_q    <= S_PTR;
              end
              default: begin
                state_q    <= S_RESP;
                done_q     <= 1'b1;
                addr_err_q <= 1'b1;
              end
            endcase
          end
        end
        S_PTR: begin
          state_q <= S_ACC;
        end
        S_ACC: begin
          state_q    <= S_RESP;
          done_q     <= 1'b1;
          addr_err_q <= !in_range;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          rdata_q <= resp_data;
        end
`ifdef IRAM_CLEAR_ON_RESET_EN
        S_CLEAR: begin
          if (clr_cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q - 1'b1;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.addr_err = addr_err_q;
  assign bus.rdata    = (state_q == S_RESP) ? resp_data : rdata_q;

  iram_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk_i (clock),
    .addr_i(ram_addr),
    .we_i  (ram_we),
    .d_i   (ram_d),
    .q_o   (ram_q)
  );

endmodule
